// File: rtl/decode_ctrl_unit.sv
// Decode-stage controller: decodes the IF/ID instruction, detects load-use hazards
// and holds the ID/EX control pipeline register (bubble on stall or branch flush).
module decode_ctrl_unit #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] InstrD,
  input  logic            ValidD,
  input  logic            FlushE,
  output logic [1:0]      ImmSrcD,
  output logic            StallF,
  output logic            StallD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            ALUSrcE,
  output logic [1:0]      ALUOpE,
  output logic            BranchE,
  output logic [RA_W-1:0] Rs1E,
  output logic [RA_W-1:0] Rs2E,
  output logic [RA_W-1:0] RdE
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1_f, rs2_f, rd_f, dec_rd;
  logic            is_lw, is_sw, is_r, is_i, is_beq;
  logic            dec_valid, rs2_used, load_use;

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic            result_src_q, result_src_d;
  logic            alu_src_q, alu_src_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            branch_q, branch_d;
  logic [RA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

  assign opcode = InstrD[6:0];
  assign rs1_f  = InstrD[15 +: RA_W];
  assign rs2_f  = InstrD[20 +: RA_W];
  assign rd_f   = InstrD[7 +: RA_W];

  always_comb begin
    is_lw     = ValidD && (opcode == OP_LW);
    is_sw     = ValidD && (opcode == OP_SW);
    is_r      = ValidD && (opcode == OP_R);
    is_i      = ValidD && (opcode == OP_I);
    is_beq    = ValidD && (opcode == OP_BEQ);
    dec_valid = is_lw | is_sw | is_r | is_i | is_beq;
    rs2_used  = is_r | is_sw | is_beq;
    dec_rd    = (is_sw || is_beq) ? '0 : rd_f;
    if (is_sw)       ImmSrcD = 2'b01;
    else if (is_beq) ImmSrcD = 2'b10;
    else             ImmSrcD = 2'b00;
  end

  // A load in EX whose destination feeds a source actually read by the ID instruction
  assign load_use = valid_q && result_src_q && (rd_q != '0) && dec_valid &&
                    ((rd_q == rs1_f) || ((rd_q == rs2_f) && rs2_used));

  assign StallF = load_use && !FlushE;
  assign StallD = load_use && !FlushE;

  always_comb begin
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = 2'b00;
    branch_d     = 1'b0;
    rs1_d        = '0;
    rs2_d        = '0;
    rd_d         = '0;
    if (dec_valid && !FlushE && !load_use) begin
      valid_d      = 1'b1;
      reg_write_d  = (is_lw || is_r || is_i) && (dec_rd != '0);
      mem_write_d  = is_sw;
      result_src_d = is_lw;
      alu_src_d    = is_lw || is_sw || is_i;
      alu_op_d     = (is_r || is_i) ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
      branch_d     = is_beq;
      rs1_d        = rs1_f;
      rs2_d        = rs2_f;
      rd_d         = dec_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= 2'b00;
      branch_q     <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      branch_q     <= branch_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
    end
  end

  assign ValidE     = valid_q;
  assign RegWriteE  = reg_write_q;
  assign MemWriteE  = mem_write_q;
  assign ResultSrcE = result_src_q;
  assign ALUSrcE    = alu_src_q;
  assign ALUOpE     = alu_op_q;
  assign BranchE    = branch_q;
  assign Rs1E       = rs1_q;
  assign Rs2E       = rs2_q;
  assign RdE        = rd_q;

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// Testbench for decode_ctrl_unit: directed hazard/flush/reset scenarios followed by
// randomized instruction streams, checked against an instruction-level reference model.
module tb_decode_ctrl_unit;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD;
  logic        ValidD;
  logic        FlushE;
  logic [1:0]  ImmSrcD;
  logic        StallF, StallD, ValidE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
  logic [1:0]  ALUOpE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int nChecks = 0;
  int nFail   = 0;

  typedef enum int {K_NONE, K_LW, K_SW, K_R, K_I, K_BEQ} kind_t;

  // Expected contents of ID/EX, one field per architectural control
  bit       mValid, mRegWrite, mMemWrite, mResultSrc, mAluSrc, mBranch;
  bit [1:0] mAluOp;
  bit [4:0] mRs1, mRs2, mRd;
  bit       lastStall;

  decode_ctrl_unit #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .FlushE(FlushE),
    .ImmSrcD(ImmSrcD), .StallF(StallF), .StallD(StallD), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE), .BranchE(BranchE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encLw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] encAdd(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] encAddi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] encSw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic kind_t kindOf(input logic [31:0] ins, input logic v);
    if (!v) return K_NONE;
    case (ins[6:0])
      7'b0000011: return K_LW;
      7'b0100011: return K_SW;
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b1100011: return K_BEQ;
      default:    return K_NONE;
    endcase
  endfunction

  function automatic bit modelLoadUse();
    kind_t k;
    bit    readsRs2;
    k = kindOf(InstrD, ValidD);
    readsRs2 = (k == K_R) || (k == K_SW) || (k == K_BEQ);
    return mValid && mResultSrc && (mRd != 0) && (k != K_NONE) &&
           ((mRd == InstrD[19:15]) || (readsRs2 && (mRd == InstrD[24:20])));
  endfunction

  function automatic bit [1:0] modelImmSrc();
    kind_t k;
    k = kindOf(InstrD, ValidD);
    if (k == K_SW)  return 2'b01;
    if (k == K_BEQ) return 2'b10;
    return 2'b00;
  endfunction

  task automatic modelReset();
    mValid = 0; mRegWrite = 0; mMemWrite = 0; mResultSrc = 0; mAluSrc = 0;
    mBranch = 0; mAluOp = 0; mRs1 = 0; mRs2 = 0; mRd = 0;
  endtask

  task automatic modelStep();
    kind_t k;
    bit    lu;
    k  = kindOf(InstrD, ValidD);
    lu = modelLoadUse();
    lastStall = lu && !FlushE;
    if (FlushE || lu || k == K_NONE) begin
      modelReset();
    end else begin
      mValid     = 1;
      mRd        = (k == K_SW || k == K_BEQ) ? 5'd0 : InstrD[11:7];
      mRegWrite  = (k == K_LW || k == K_R || k == K_I) && (mRd != 0);
      mMemWrite  = (k == K_SW);
      mResultSrc = (k == K_LW);
      mAluSrc    = (k == K_LW || k == K_SW || k == K_I);
      mAluOp     = (k == K_R || k == K_I) ? 2'd2 : ((k == K_BEQ) ? 2'd1 : 2'd0);
      mBranch    = (k == K_BEQ);
      mRs1       = InstrD[19:15];
      mRs2       = InstrD[24:20];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit stall;
    stall = modelLoadUse() && !FlushE;
    chk({tag, ".ImmSrcD"},    {30'd0, ImmSrcD},    {30'd0, modelImmSrc()});
    chk({tag, ".StallF"},     {31'd0, StallF},     {31'd0, stall});
    chk({tag, ".StallD"},     {31'd0, StallD},     {31'd0, stall});
    chk({tag, ".ValidE"},     {31'd0, ValidE},     {31'd0, mValid});
    chk({tag, ".RegWriteE"},  {31'd0, RegWriteE},  {31'd0, mRegWrite});
    chk({tag, ".MemWriteE"},  {31'd0, MemWriteE},  {31'd0, mMemWrite});
    chk({tag, ".ResultSrcE"}, {31'd0, ResultSrcE}, {31'd0, mResultSrc});
    chk({tag, ".ALUSrcE"},    {31'd0, ALUSrcE},    {31'd0, mAluSrc});
    chk({tag, ".ALUOpE"},     {30'd0, ALUOpE},     {30'd0, mAluOp});
    chk({tag, ".BranchE"},    {31'd0, BranchE},    {31'd0, mBranch});
    chk({tag, ".Rs1E"},       {27'd0, Rs1E},       {27'd0, mRs1});
    chk({tag, ".Rs2E"},       {27'd0, Rs2E},       {27'd0, mRs2});
    chk({tag, ".RdE"},        {27'd0, RdE},        {27'd0, mRd});
  endtask

  // Drive one ID-stage instruction, then check everything at the falling edge
  task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic v, input logic f);
    InstrD = ins;
    ValidD = v;
    FlushE = f;
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic clockEdge();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randInstr(output logic v);
    logic [31:0] ins;
    int          sel;
    ins = $urandom;
    sel = $urandom_range(0, 7);
    v   = 1'b1;
    case (sel)
      0, 1: ins[6:0] = 7'b0000011;
      2:    ins[6:0] = 7'b0100011;
      3:    ins[6:0] = 7'b0110011;
      4:    ins[6:0] = 7'b0010011;
      5:    ins[6:0] = 7'b1100011;
      6:    ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0110111;
      default: begin ins[6:0] = 7'b0110011; v = 1'b0; end
    endcase
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    logic [31:0] rIns;
    logic        rV;
    rst = 1'b0; InstrD = 32'd0; ValidD = 1'b0; FlushE = 1'b0;
    lastStall = 0;
    modelReset();
    #3;
    checkOutput("reset");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;

    $display("[TB] load-use stall then resume");
    applyStimulus("t2.lw", encLw(5'd5, 5'd1, 12'd8), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t2.add", encAdd(5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
    chk("t2.StallF", {31'd0, StallF}, 32'd1);
    chk("t2.StallD", {31'd0, StallD}, 32'd1);
    clockEdge();
    chk("t2.bubble.ValidE", {31'd0, ValidE}, 32'd0);
    applyStimulus("t2.add_again", encAdd(5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
    chk("t2.nostall", {31'd0, StallF}, 32'd0);
    clockEdge();
    chk("t2.add.ValidE", {31'd0, ValidE}, 32'd1);
    chk("t2.add.RdE", {27'd0, RdE}, 32'd6);

    $display("[TB] x0 load, rs1 hit, unused rs2");
    applyStimulus("t3.lw0", encLw(5'd0, 5'd1, 12'd0), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t3.add_x0", encAdd(5'd6, 5'd0, 5'd2), 1'b1, 1'b0);
    chk("t3.x0.StallF", {31'd0, StallF}, 32'd0);
    clockEdge();
    applyStimulus("t3.lw5", encLw(5'd5, 5'd1, 12'd4), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t3.addi_hit", encAddi(5'd7, 5'd5, 12'd1), 1'b1, 1'b0);
    chk("t3.rs1hit.StallF", {31'd0, StallF}, 32'd1);
    clockEdge();
    applyStimulus("t3.addi_resume", encAddi(5'd7, 5'd5, 12'd1), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t3.lw5b", encLw(5'd5, 5'd1, 12'd4), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t3.addi_rs2", encAddi(5'd7, 5'd3, 12'd5), 1'b1, 1'b0);
    chk("t3.rs2unused.StallF", {31'd0, StallF}, 32'd0);
    clockEdge();

    $display("[TB] store decode");
    applyStimulus("t4.sw", encSw(5'd3, 5'd2, 12'd12), 1'b1, 1'b0);
    chk("t4.ImmSrcD", {30'd0, ImmSrcD}, 32'd1);
    clockEdge();
    chk("t4.MemWriteE", {31'd0, MemWriteE}, 32'd1);
    chk("t4.RegWriteE", {31'd0, RegWriteE}, 32'd0);
    chk("t4.RdE", {27'd0, RdE}, 32'd0);
    chk("t4.ALUSrcE", {31'd0, ALUSrcE}, 32'd1);

    $display("[TB] flush coincident with load-use");
    applyStimulus("t5.lw", encLw(5'd5, 5'd1, 12'd8), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t5.flush", encAdd(5'd6, 5'd5, 5'd2), 1'b1, 1'b1);
    chk("t5.StallF", {31'd0, StallF}, 32'd0);
    chk("t5.StallD", {31'd0, StallD}, 32'd0);
    clockEdge();
    chk("t5.ValidE", {31'd0, ValidE}, 32'd0);

    $display("[TB] unknown opcode");
    applyStimulus("t6.unk", 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("t6.StallF", {31'd0, StallF}, 32'd0);
    clockEdge();
    chk("t6.ValidE", {31'd0, ValidE}, 32'd0);
    chk("t6.RegWriteE", {31'd0, RegWriteE}, 32'd0);

    $display("[TB] asynchronous reset during a stall");
    applyStimulus("t1.lw", encLw(5'd5, 5'd1, 12'd8), 1'b1, 1'b0);
    clockEdge();
    applyStimulus("t1.add", encAdd(5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
    chk("t1.pre.StallF", {31'd0, StallF}, 32'd1);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("t1.async");
    chk("t1.async.StallD", {31'd0, StallD}, 32'd0);
    chk("t1.async.ValidE", {31'd0, ValidE}, 32'd0);
    #1 rst = 1'b1;
    clockEdge();
    chk("t1.after.ValidE", {31'd0, ValidE}, 32'd1);
    chk("t1.after.RdE", {27'd0, RdE}, 32'd6);

    $display("[TB] randomized stream");
    lastStall = 0;
    rIns = 32'd0;
    rV = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!lastStall) rIns = randInstr(rV);
      applyStimulus("rand", rIns, rV, ($urandom_range(0, 9) == 0));
      clockEdge();
    end
    applyStimulus("final", 32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
